// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep scheduler for the DDS core: takes one sweep config over valid/ready
// and steps the frequency word K from start to stop with a programmable dwell per word.
module dds_sweep_ctrl #(
  parameter int KW      = 32,
  parameter int PW      = 11,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [KW-1:0]      cfg_k_start_i,
  input  logic [KW-1:0]      cfg_k_stop_i,
  input  logic [KW-1:0]      cfg_k_step_i,
  input  logic [DWELL_W-1:0] cfg_dwell_i,
  input  logic [PW-1:0]      cfg_p_i,
  input  logic [1:0]         cfg_mode_i,
  input  logic               abort_i,
  output logic [KW-1:0]      k_o,
  output logic [PW-1:0]      p_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               sweep_dir_o
);

  typedef enum logic [1:0] {IDLE, DWELL, DONE} state_e;

  localparam logic [1:0] MODE_SINGLE   = 2'b00;
  localparam logic [1:0] MODE_REPEAT   = 2'b01;
  localparam logic [1:0] MODE_TRIANGLE = 2'b10;

  state_e             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [PW-1:0]      p_q, p_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic [KW-1:0]      start_q, start_d;
  logic [KW-1:0]      stop_q, stop_d;
  logic [KW-1:0]      step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [1:0]         mode_q, mode_d;

  // Step arithmetic is one bit wider so K saturates at the leg limit instead of wrapping.
  logic [KW:0]   sum_w;
  logic [KW:0]   diff_w;
  logic [KW-1:0] up_k;
  logic [KW-1:0] dn_k;
  logic          at_stop;
  logic          at_start;

  assign sum_w    = {1'b0, k_q} + {1'b0, step_q};
  assign diff_w   = {1'b0, k_q} - {1'b0, step_q};
  assign up_k     = (sum_w > {1'b0, stop_q}) ? stop_q : sum_w[KW-1:0];
  assign dn_k     = (diff_w[KW] || (diff_w[KW-1:0] < start_q)) ? start_q : diff_w[KW-1:0];
  assign at_stop  = (k_q == stop_q);
  assign at_start = (k_q == start_q);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    start_d = start_q;
    stop_d  = stop_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    mode_d  = mode_q;

    unique case (state_q)
      IDLE: begin
        if (cfg_valid_i) begin
          start_d = cfg_k_start_i;
          stop_d  = (cfg_k_start_i > cfg_k_stop_i) ? cfg_k_start_i : cfg_k_stop_i;
          step_d  = (cfg_k_step_i == '0) ? KW'(1) : cfg_k_step_i;
          dwell_d = cfg_dwell_i;
          mode_d  = (cfg_mode_i == 2'b11) ? MODE_SINGLE : cfg_mode_i;
          k_d     = cfg_k_start_i;
          p_d     = cfg_p_i;
          cnt_d   = '0;
          dir_d   = 1'b0;
          state_d = DWELL;
        end
      end

      DWELL: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (cnt_q == dwell_q) begin
          cnt_d = '0;
          if (!dir_q) begin
            if (!at_stop) begin
              k_d = up_k;
            end else begin
              case (mode_q)
                MODE_REPEAT:   k_d = start_q;
                MODE_TRIANGLE: begin
                  dir_d = 1'b1;
                  k_d   = at_start ? k_q : dn_k;
                end
                default:       state_d = DONE;
              endcase
            end
          end else begin
            // Only a triangle sweep ever runs the falling leg.
            if (!at_start) begin
              k_d = dn_k;
            end else begin
              dir_d = 1'b0;
              k_d   = at_stop ? k_q : up_k;
            end
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      mode_q  <= MODE_SINGLE;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
    end
  end

  assign cfg_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q == DWELL);
  assign done_o      = (state_q == DONE);
  assign k_o         = k_q;
  assign p_o         = p_q;
  assign sweep_dir_o = dir_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: per-cycle expectations are queued when a sweep
// is launched and compared at each falling edge while the sweep runs.
module tb_dds_sweep_ctrl;

  localparam int KW = 32;
  localparam int PW = 11;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [KW-1:0] cfg_k_start = '0;
  logic [KW-1:0] cfg_k_stop = '0;
  logic [KW-1:0] cfg_k_step = '0;
  logic [DW-1:0] cfg_dwell = '0;
  logic [PW-1:0] cfg_p = '0;
  logic [1:0]    cfg_mode = '0;
  logic          abort = 1'b0;
  logic [KW-1:0] k;
  logic [PW-1:0] p;
  logic          busy;
  logic          done;
  logic          sweep_dir;

  dds_sweep_ctrl #(.KW(KW), .PW(PW), .DWELL_W(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_valid_i   (cfg_valid),
    .cfg_ready_o   (cfg_ready),
    .cfg_k_start_i (cfg_k_start),
    .cfg_k_stop_i  (cfg_k_stop),
    .cfg_k_step_i  (cfg_k_step),
    .cfg_dwell_i   (cfg_dwell),
    .cfg_p_i       (cfg_p),
    .cfg_mode_i    (cfg_mode),
    .abort_i       (abort),
    .k_o           (k),
    .p_o           (p),
    .busy_o        (busy),
    .done_o        (done),
    .sweep_dir_o   (sweep_dir)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [KW-1:0] k;
    logic [PW-1:0] p;
    logic          busy;
    logic          done;
    logic          dir;
    logic          ready;
    logic          chkDir;
    logic          abortNext;
    logic          validNext;
    logic          loadNext;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   passes = 0;

  // Config loaded onto the cfg bus mid-sweep when an entry asks for it.
  logic [KW-1:0] nextStart, nextStop, nextStep;
  logic [DW-1:0] nextDwell;
  logic [PW-1:0] nextP;
  logic [1:0]    nextMode;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic pushExp(input logic [KW-1:0] ek, input logic [PW-1:0] ep,
                         input logic eBusy, input logic eDone, input logic eDir, input logic eReady,
                         input logic eChkDir, input logic eAbortNext, input logic eValidNext,
                         input logic eLoadNext);
    exp_t e;
    e.k = ek; e.p = ep; e.busy = eBusy; e.done = eDone; e.dir = eDir; e.ready = eReady;
    e.chkDir = eChkDir; e.abortNext = eAbortNext; e.validNext = eValidNext; e.loadNext = eLoadNext;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [KW-1:0] start, input logic [KW-1:0] stop,
                               input logic [KW-1:0] step, input logic [DW-1:0] dwell,
                               input logic [PW-1:0] ph, input logic [1:0] mode,
                               input logic withAbort, input logic holdValid);
    @(negedge clk);
    checkOutput("ready_before_accept", 64'(cfg_ready), 64'(1'b1));
    cfg_k_start = start;
    cfg_k_stop  = stop;
    cfg_k_step  = step;
    cfg_dwell   = dwell;
    cfg_p       = ph;
    cfg_mode    = mode;
    cfg_valid   = 1'b1;
    abort       = withAbort;
    @(posedge clk);
    #1;
    cfg_valid = holdValid;
    abort     = 1'b0;
  endtask

  // Pops one expectation per cycle; the queue length bounds the run.
  task automatic runScoreboard(input string name);
    exp_t e;
    int   idx = 0;
    while (expQ.size() > 0) begin
      @(negedge clk);
      e = expQ.pop_front();
      checkOutput($sformatf("%s[%0d].K", name, idx), 64'(k), 64'(e.k));
      checkOutput($sformatf("%s[%0d].P", name, idx), 64'(p), 64'(e.p));
      checkOutput($sformatf("%s[%0d].busy", name, idx), 64'(busy), 64'(e.busy));
      checkOutput($sformatf("%s[%0d].done", name, idx), 64'(done), 64'(e.done));
      checkOutput($sformatf("%s[%0d].ready", name, idx), 64'(cfg_ready), 64'(e.ready));
      if (e.chkDir) checkOutput($sformatf("%s[%0d].dir", name, idx), 64'(sweep_dir), 64'(e.dir));
      abort     = e.abortNext;
      cfg_valid = e.validNext;
      if (e.loadNext) begin
        cfg_k_start = nextStart;
        cfg_k_stop  = nextStop;
        cfg_k_step  = nextStep;
        cfg_dwell   = nextDwell;
        cfg_p       = nextP;
        cfg_mode    = nextMode;
      end
      idx++;
    end
    abort     = 1'b0;
    cfg_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    logic [KW-1:0] triK[7];
    logic          triD[7];
    logic [KW-1:0] ovK[3];

    #3;
    checkOutput("reset.K", 64'(k), 64'(0));
    checkOutput("reset.P", 64'(p), 64'(0));
    checkOutput("reset.busy", 64'(busy), 64'(0));
    checkOutput("reset.done", 64'(done), 64'(0));
    checkOutput("reset.dir", 64'(sweep_dir), 64'(0));
    checkOutput("reset.ready", 64'(cfg_ready), 64'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single sweep");
    for (int i = 0; i < 4; i++)
      repeat (3) pushExp(KW'(100 + 10 * i), 11'h12, 1, 0, 0, 0, 1, 0, 0, 0);
    pushExp(KW'(130), 11'h12, 0, 1, 0, 0, 1, 0, 0, 0);
    pushExp(KW'(130), 11'h12, 0, 0, 0, 1, 1, 0, 0, 0);
    applyStimulus(KW'(100), KW'(130), KW'(10), DW'(2), 11'h12, 2'b00, 1'b0, 1'b0);
    runScoreboard("single");

    $display("[TB] clamped sweep, abort alongside accept");
    pushExp(KW'(0),  11'h7FF, 1, 0, 0, 0, 1, 0, 0, 0);
    pushExp(KW'(10), 11'h7FF, 1, 0, 0, 0, 1, 0, 0, 0);
    pushExp(KW'(20), 11'h7FF, 1, 0, 0, 0, 1, 0, 0, 0);
    pushExp(KW'(25), 11'h7FF, 1, 0, 0, 0, 1, 0, 0, 0);
    pushExp(KW'(25), 11'h7FF, 0, 1, 0, 0, 1, 0, 0, 0);
    pushExp(KW'(25), 11'h7FF, 0, 0, 0, 1, 1, 0, 0, 0);
    applyStimulus(KW'(0), KW'(25), KW'(10), DW'(0), 11'h7FF, 2'b00, 1'b1, 1'b0);
    runScoreboard("clamp");

    $display("[TB] triangle sweep with abort");
    triK = '{KW'(0), KW'(10), KW'(20), KW'(10), KW'(0), KW'(10), KW'(20)};
    triD = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++)
      pushExp(triK[i], 11'h055, 1, 0, triD[i], 0, 1, (i == 6) ? 1'b1 : 1'b0, 0, 0);
    pushExp(KW'(20), 11'h055, 0, 0, 0, 1, 0, 0, 0, 0);
    pushExp(KW'(20), 11'h055, 0, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus(KW'(0), KW'(20), KW'(10), DW'(0), 11'h055, 2'b10, 1'b0, 1'b0);
    runScoreboard("triangle");

    $display("[TB] repeat sweep near full scale");
    ovK = '{32'hFFFF_FFF0, 32'hFFFF_FFF8, 32'hFFFF_FFFF};
    for (int i = 0; i < 7; i++)
      pushExp(ovK[i % 3], 11'h001, 1, 0, 0, 0, 1, (i == 6) ? 1'b1 : 1'b0, 0, 0);
    pushExp(32'hFFFF_FFF0, 11'h001, 0, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus(32'hFFFF_FFF0, 32'hFFFF_FFFF, KW'(8), DW'(0), 11'h001, 2'b01, 1'b0, 1'b0);
    runScoreboard("overflow");

    $display("[TB] config held valid across a sweep, zero step");
    nextStart = KW'(50); nextStop = KW'(52); nextStep = KW'(0);
    nextDwell = DW'(0);  nextP = 11'h009;    nextMode = 2'b11;
    for (int i = 0; i < 6; i++)
      pushExp(KW'(5 + i / 2), 11'h003, 1, 0, 0, 0, 1, 0, 1, (i == 0) ? 1'b1 : 1'b0);
    pushExp(KW'(7), 11'h003, 0, 1, 0, 0, 1, 0, 1, 0);
    pushExp(KW'(7), 11'h003, 0, 0, 0, 1, 1, 0, 1, 0);
    pushExp(KW'(50), 11'h009, 1, 0, 0, 0, 1, 0, 0, 0);
    pushExp(KW'(51), 11'h009, 1, 0, 0, 0, 1, 0, 0, 0);
    pushExp(KW'(52), 11'h009, 1, 0, 0, 0, 1, 0, 0, 0);
    pushExp(KW'(52), 11'h009, 0, 1, 0, 0, 1, 0, 0, 0);
    pushExp(KW'(52), 11'h009, 0, 0, 0, 1, 1, 0, 0, 0);
    applyStimulus(KW'(5), KW'(7), KW'(0), DW'(1), 11'h003, 2'b00, 1'b0, 1'b1);
    runScoreboard("handshake");

    $display("[TB] asynchronous reset mid-sweep");
    applyStimulus(KW'(100), KW'(130), KW'(10), DW'(2), 11'h066, 2'b00, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset.K", 64'(k), 64'(0));
    checkOutput("async_reset.P", 64'(p), 64'(0));
    checkOutput("async_reset.busy", 64'(busy), 64'(0));
    checkOutput("async_reset.done", 64'(done), 64'(0));
    checkOutput("async_reset.ready", 64'(cfg_ready), 64'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("after_reset.busy", 64'(busy), 64'(0));
    checkOutput("after_reset.done", 64'(done), 64'(0));
    checkOutput("after_reset.K", 64'(k), 64'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
